// File: rtl/mac_pkg.sv
// Shared types and helpers for the row-accumulating MAC path.
package mac_pkg;

    // Controller states: accumulate, wait for pipeline flush, drain.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SCAN = 2'd2
    } state_t;

    // Widest accumulator supported by the saturation limits below.
    localparam int MAC_MAX_W = 64;

    // Signed limits at the widest width; narrower widths shift these down.
    localparam logic [MAC_MAX_W-1:0] SAT_MAX_WIDE = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [MAC_MAX_W-1:0] SAT_MIN_WIDE = 64'h8000_0000_0000_0000;

    // Number of bits needed to hold the value v (at least 1).
    function automatic int mac_log2(input int v);
        int n;
        for (n = 1; n < 31; n++) begin
            if ((v >> n) == 0) break;
        end
        return n;
    endfunction

endpackage

// File: rtl/mac_accum_add_pipe.sv
// Registered adder of ADD_LAT stages; row and valid travel with the sum.
// Build option MAC_SATURATE_EN: clamp signed overflow in the final stage
// instead of wrapping. Latency is the same either way.
module add_pipe
    import mac_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int ROW_W   = 10,
    parameter int ADD_LAT = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_vld,
    input  logic [ROW_W-1:0]                in_row,
    input  logic signed [DATA_W-1:0]        in_a,
    input  logic signed [DATA_W-1:0]        in_b,
    output logic [ADD_LAT-1:0]              stg_vld,
    output logic [ADD_LAT-1:0][ROW_W-1:0]   stg_row,
    output logic signed [DATA_W-1:0]        out_sum
);

    // One extra bit keeps the true sum so the final stage can detect overflow.
    logic signed [DATA_W:0] sum_p [ADD_LAT];

`ifdef MAC_SATURATE_EN
    localparam logic [MAC_MAX_W-1:0] SMAX_W = SAT_MAX_WIDE >> (MAC_MAX_W - DATA_W);
    localparam logic [MAC_MAX_W-1:0] SMIN_W = SAT_MIN_WIDE >> (MAC_MAX_W - DATA_W);
    localparam logic signed [DATA_W-1:0] SAT_MAX = SMAX_W[DATA_W-1:0];
    localparam logic signed [DATA_W-1:0] SAT_MIN = SMIN_W[DATA_W-1:0];

    // Clamp to the signed range when the two top bits disagree.
    function automatic logic signed [DATA_W-1:0] final_stage(input logic signed [DATA_W:0] s);
        if (s[DATA_W] != s[DATA_W-1]) begin
            return s[DATA_W] ? SAT_MIN : SAT_MAX;
        end
        return s[DATA_W-1:0];
    endfunction
`else
    // Plain modulo 2^DATA_W result.
    function automatic logic signed [DATA_W-1:0] final_stage(input logic signed [DATA_W:0] s);
        return s[DATA_W-1:0];
    endfunction
`endif

    // Stage valids are control and are cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_vld <= '0;
        end else begin
            stg_vld[0] <= in_vld;
            for (int k = 1; k < ADD_LAT; k++) begin
                stg_vld[k] <= stg_vld[k-1];
            end
        end
    end

    // Stage data: add in the first stage, then carry sum and row forward.
    always_ff @(posedge clk) begin
        sum_p[0]   <= {in_a[DATA_W-1], in_a} + {in_b[DATA_W-1], in_b};
        stg_row[0] <= in_row;
        for (int k = 1; k < ADD_LAT; k++) begin
            sum_p[k]   <= sum_p[k-1];
            stg_row[k] <= stg_row[k-1];
        end
    end

    assign out_sum = final_stage(sum_p[ADD_LAT-1]);

endmodule

// File: rtl/mac_accum.sv
// Per-row accumulator: (row, product) pairs are summed into a DEPTH-entry
// RAM through add_pipe; an in-flight scoreboard stalls same-row samples
// until their earlier sum is written back. eof drains all touched rows in
// ascending order. Build option MAC_SATURATE_EN selects clamping addition.
module mac_accum
    import mac_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 1024,
    parameter int ROW_W   = mac_log2(DEPTH - 1),
    parameter int ADD_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ROW_W-1:0]  in_row,
    input  logic [DATA_W-1:0] in_val,
    input  logic              eof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ROW_W-1:0]  out_row,
    output logic [DATA_W-1:0] out_val,
    output logic              busy,
    output logic              done
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(DEPTH - 1);

    state_t state, state_nxt;

    logic [ROW_W-1:0]  scan_addr;
    logic              scan_chk;
    logic              scan_step;
    logic              scan_last;
    logic              done_r;

    logic [DEPTH-1:0]  vbits;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data;
    logic              rd_vld;
    logic              rd_en;
    logic [ROW_W-1:0]  rd_addr;

    logic              accept;
    logic              hazard;
    logic              pipe_busy;
    logic              handshake;

    logic                     vld_p0;
    logic [ROW_W-1:0]         row_p0;
    logic signed [DATA_W-1:0] val_p0;
    logic signed [DATA_W-1:0] operand;

    logic [ADD_LAT-1:0]            stg_vld;
    logic [ADD_LAT-1:0][ROW_W-1:0] stg_row;
    logic signed [DATA_W-1:0]      wb_sum;
    logic                          wb_en;
    logic [ROW_W-1:0]              wb_row;

    // A row is in flight from accept (p0) through its writeback stage.
    always_comb begin
        hazard = vld_p0 && (row_p0 == in_row);
        for (int k = 0; k < ADD_LAT; k++) begin
            if (stg_vld[k] && (stg_row[k] == in_row)) hazard = 1'b1;
        end
    end

    assign pipe_busy = vld_p0 || (|stg_vld);
    assign in_ready  = (state == IDLE) && !rst && !hazard;
    assign accept    = in_valid && in_ready;

    assign out_valid = (state == SCAN) && scan_chk && rd_vld;
    assign out_row   = out_valid ? scan_addr : '0;
    assign out_val   = out_valid ? rd_data : '0;
    assign handshake = out_valid && out_ready;
    assign scan_step = (state == SCAN) && scan_chk && (!rd_vld || out_ready);
    assign scan_last = (scan_addr == LAST_ROW);

    assign busy = (state != IDLE) || pipe_busy;
    assign done = done_r;

    assign rd_en   = accept || ((state == SCAN) && !scan_chk);
    assign rd_addr = (state == SCAN) ? scan_addr : in_row;

    assign wb_en  = stg_vld[ADD_LAT-1];
    assign wb_row = stg_row[ADD_LAT-1];

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: eof starts the flush, empty pipeline starts the scan.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (eof) state_nxt = WAIT;
            WAIT:    if (!pipe_busy) state_nxt = SCAN;
            SCAN:    if (scan_step && scan_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Scan address and read/check phase; done pulses after the last entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_addr <= '0;
            scan_chk  <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= scan_step && scan_last;
            if (state == WAIT) begin
                scan_addr <= '0;
                scan_chk  <= 1'b0;
            end else if (state == SCAN) begin
                if (!scan_chk) begin
                    scan_chk <= 1'b1;
                end else if (scan_step) begin
                    scan_chk <= 1'b0;
                    if (!scan_last) scan_addr <= scan_addr + 1'b1;
                end
            end
        end
    end

    // Accumulator RAM: synchronous read, write-back from the adder output.
    always_ff @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        if (wb_en) mem[wb_row] <= wb_sum;
    end

    // Entry valid bits: set on write-back, cleared when drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            vbits  <= '0;
            rd_vld <= 1'b0;
        end else begin
            if (rd_en) rd_vld <= vbits[rd_addr];
            if (wb_en) vbits[wb_row] <= 1'b1;
            if (handshake) vbits[scan_addr] <= 1'b0;
        end
    end

    // ---- stage p0: accepted sample waits one cycle for the RAM read ----
    always_ff @(posedge clk) begin
        if (rst) vld_p0 <= 1'b0;
        else     vld_p0 <= accept;
    end

    // Sample data registered alongside the read (no reset on data).
    always_ff @(posedge clk) begin
        row_p0 <= in_row;
        val_p0 <= in_val;
    end

    assign operand = rd_vld ? rd_data : '0;

    add_pipe #(
        .DATA_W  (DATA_W),
        .ROW_W   (ROW_W),
        .ADD_LAT (ADD_LAT)
    ) u_add_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (vld_p0),
        .in_row  (row_p0),
        .in_a    (operand),
        .in_b    (val_p0),
        .stg_vld (stg_vld),
        .stg_row (stg_row),
        .out_sum (wb_sum)
    );

endmodule

// File: tb/tb_mac_accum.sv
// Directed bench for mac_accum (DATA_W=8, DEPTH=16, ADD_LAT=4).
module tb_mac_accum;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 16;
    localparam int ROW_W   = 4;
    localparam int ADD_LAT = 4;

`ifdef MAC_SATURATE_EN
    localparam int OVF_EXP = 127;
`else
    localparam int OVF_EXP = -56;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [ROW_W-1:0]  in_row;
    logic [DATA_W-1:0] in_val;
    logic              eof;
    logic              out_valid;
    logic              out_ready;
    logic [ROW_W-1:0]  out_row;
    logic [DATA_W-1:0] out_val;
    logic              busy;
    logic              done;

    int total = 0;
    int bad   = 0;

    mac_accum #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .ROW_W   (ROW_W),
        .ADD_LAT (ADD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .in_val    (in_val),
        .eof       (eof),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_val   (out_val),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one sample and hold it until accepted; returns stall cycles.
    task automatic send(input int row, input int val, output int stalls);
        bit got;
        got      = 1'b0;
        stalls   = 0;
        in_valid = 1'b1;
        in_row   = ROW_W'(row);
        in_val   = DATA_W'(val);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
            stalls++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("send_accept", int'(got), 1);
    endtask

    task automatic pulse_eof();
        eof = 1'b1;
        @(posedge clk); #1;
        eof = 1'b0;
    endtask

    // Wait for the next result and check it; out_ready is assumed high.
    task automatic expect_out(input string tag, input int row, input int val);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_present"}, int'(got), 1);
        chk({tag, "_row"}, int'(out_row), row);
        chk({tag, "_val"}, int'($signed(out_val)), val);
        @(posedge clk); #1;
    endtask

    // Wait for done with no further results, then check it lasts one cycle.
    task automatic expect_done(input string tag);
        bit got;
        int extra;
        got   = 1'b0;
        extra = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_valid) extra++;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_done"}, int'(got), 1);
        chk({tag, "_extra_out"}, extra, 0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, int'(done), 0);
        chk({tag, "_idle_busy"}, int'(busy), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int s;
        int ssum;
        bit found;
        bit hold_ok;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_row    = '0;
        in_val    = '0;
        eof       = 1'b0;
        out_ready = 1'b1;

        // Reset state
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_row", int'(out_row), 0);
        chk("rst_out_val", int'(out_val), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;

        // Row reuse: 5 + 7 - 2 into row 3, ADD_LAT+1 stall cycles between
        send(3, 5, s);
        chk("reuse_stall0", s, 0);
        send(3, 7, s);
        chk("reuse_stall1", s, ADD_LAT + 1);
        send(3, -2, s);
        chk("reuse_stall2", s, ADD_LAT + 1);
        pulse_eof();
        expect_out("reuse", 3, 10);
        expect_done("reuse");

        // Distinct rows back to back, drained in ascending order
        ssum = 0;
        for (int r = 0; r < 8; r++) begin
            send(r, 1, s);
            ssum += s;
        end
        chk("seq_stalls", ssum, 0);
        pulse_eof();
        for (int r = 0; r < 8; r++) begin
            expect_out("seq", r, 1);
        end
        expect_done("seq");

        // eof coinciding with an accepted sample includes that sample
        in_valid = 1'b1;
        in_row   = 4'd2;
        in_val   = 8'd9;
        eof      = 1'b1;
        @(negedge clk);
        chk("eofs_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        eof      = 1'b0;
        expect_out("eofs", 2, 9);
        expect_done("eofs");

        // Output backpressure: result must hold for 20 stalled cycles
        send(5, 4, s);
        send(6, 3, s);
        out_ready = 1'b0;
        pulse_eof();
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("bp_present", int'(found), 1);
        hold_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!(out_valid === 1'b1 && out_row === 4'd5 && out_val === 8'd4)) hold_ok = 1'b0;
        end
        chk("bp_hold", int'(hold_ok), 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        expect_out("bp5", 5, 4);
        expect_out("bp6", 6, 3);
        expect_done("bp");

        // Reset mid-scan after the first result discards the rest
        send(1, 1, s);
        send(4, 2, s);
        pulse_eof();
        expect_out("rs1", 1, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rs_out_valid", int'(out_valid), 0);
        chk("rs_busy", int'(busy), 0);
        @(posedge clk); #1;
        pulse_eof();
        expect_done("rs_empty");

        // Overflow: 100 + 100 in 8 bits
        send(1, 100, s);
        send(1, 100, s);
        pulse_eof();
        expect_out("ovf", 1, OVF_EXP);
        expect_done("ovf");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
